// File: rtl/resource_lock_arbiter.sv
// resource_lock_arbiter: round-robin lock allocator for a pool of shared execution units (watchdog under RESOURCE_LOCK_WATCHDOG_EN)
module resource_lock_arbiter #(
  parameter int NUM_PORTS = 8,
  parameter int NUM_UNITS = 4,
  parameter int ID_WIDTH = 16,
  parameter int LOCK_TIMEOUT = 255,
  localparam int UW = NUM_UNITS > 1 ? $clog2(NUM_UNITS) : 1,
  localparam int PW = NUM_PORTS > 1 ? $clog2(NUM_PORTS) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rollback,
  input  logic [NUM_PORTS-1:0] req_valid,
  input  logic [ID_WIDTH-1:0]  req_id [NUM_PORTS],
  output logic [NUM_PORTS-1:0] grant,
  output logic [UW-1:0]        grant_unit [NUM_PORTS],
  output logic [NUM_UNITS-1:0] unit_busy,
  output logic                 timeout_pulse
);
  logic [NUM_UNITS-1:0] locked;
  logic [PW-1:0]        owner [NUM_UNITS];
  logic [ID_WIDTH-1:0]  owner_id [NUM_UNITS];
  logic [PW-1:0]        rr_ptr, rr_next, last;
  logic [NUM_PORTS-1:0] owns, elig, mask;
  logic [NUM_UNITS-1:0] rel, wd, alloc, avail;
  logic [PW-1:0]        alloc_port [NUM_UNITS];
  logic                 any, take;
  int                   p;
`ifdef RESOURCE_LOCK_WATCHDOG_EN
  localparam int CW = $clog2(LOCK_TIMEOUT + 1);
  logic [CW-1:0] cnt [NUM_UNITS];
  // a lock that survives its last allowed cycle is force-released; a normal release wins
  always_comb
    for (int u = 0; u < NUM_UNITS; u++)
      wd[u] = locked[u] & ~rel[u] & (cnt[u] == CW'(LOCK_TIMEOUT - 1));
  // per-unit age counters and the mask that keeps a timed-out port out until it lets go
  always_ff @(posedge clk)
    if (!rst_n) begin
      mask <= '0;
      for (int u = 0; u < NUM_UNITS; u++) cnt[u] <= '0;
    end else begin
      for (int u = 0; u < NUM_UNITS; u++) cnt[u] <= alloc[u] ? '0 : locked[u] ? cnt[u] + 1'b1 : cnt[u];
      for (int i = 0; i < NUM_PORTS; i++) if (!req_valid[i]) mask[i] <= 1'b0;
      for (int u = 0; u < NUM_UNITS; u++) if (wd[u] && !rollback) mask[owner[u]] <= 1'b1;
    end
`else
  assign wd = '0;
  assign mask = '0;
`endif
  // outputs are a decode of registered lock state, so grants appear one cycle after the request
  always_comb begin
    owns = '0;
    for (int i = 0; i < NUM_PORTS; i++) grant_unit[i] = '0;
    for (int u = 0; u < NUM_UNITS; u++)
      if (locked[u]) begin
        owns[owner[u]] = 1'b1;
        grant_unit[owner[u]] = UW'(u);
      end
    grant = owns;
    unit_busy = locked;
  end
  // release on dropped valid or a new issue ID; allocate only units already free this cycle
  always_comb begin
    for (int u = 0; u < NUM_UNITS; u++)
      rel[u] = locked[u] & (~req_valid[owner[u]] | (req_id[owner[u]] != owner_id[u]));
    elig = req_valid & ~owns & ~mask & {NUM_PORTS{~rollback}};
    avail = ~locked;
    alloc = '0;
    for (int u = 0; u < NUM_UNITS; u++) alloc_port[u] = '0;
    any = 1'b0;
    last = rr_ptr;
    p = 0;
    take = 1'b0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      p = int'(rr_ptr) + k;
      if (p >= NUM_PORTS) p = p - NUM_PORTS;
      take = 1'b0;
      if (elig[p])
        for (int u = 0; u < NUM_UNITS; u++)
          if (!take && avail[u]) begin
            take = 1'b1;
            avail[u] = 1'b0;
            alloc[u] = 1'b1;
            alloc_port[u] = PW'(p);
            last = PW'(p);
            any = 1'b1;
          end
    end
    rr_next = !any ? rr_ptr : (int'(last) == NUM_PORTS - 1) ? '0 : last + 1'b1;
  end
  // lock table, round-robin pointer and timeout pulse
  always_ff @(posedge clk)
    if (!rst_n) begin
      locked <= '0;
      rr_ptr <= '0;
      timeout_pulse <= 1'b0;
      for (int u = 0; u < NUM_UNITS; u++) begin
        owner[u] <= '0;
        owner_id[u] <= '0;
      end
    end else if (rollback) begin
      locked <= '0;
      timeout_pulse <= 1'b0;
    end else begin
      for (int u = 0; u < NUM_UNITS; u++)
        if (alloc[u]) begin
          locked[u] <= 1'b1;
          owner[u] <= alloc_port[u];
          owner_id[u] <= req_id[alloc_port[u]];
        end else if (rel[u] || wd[u]) locked[u] <= 1'b0;
      rr_ptr <= rr_next;
      timeout_pulse <= |wd;
    end
endmodule

// File: tb/tb_resource_lock_arbiter.sv
// tb_resource_lock_arbiter: table-driven scoreboard bench for resource_lock_arbiter
module tb_resource_lock_arbiter;
  typedef struct {
    logic        rst_n, rb;
    logic [7:0]  rv, bump, eg;
    logic [3:0]  eb;
    logic [31:0] egu;
  } vec_t;
  logic       clk = 1'b0, rst_n, rollback, timeout_pulse;
  logic [7:0] req_valid, grant;
  logic [15:0] req_id [8];
  logic [1:0] grant_unit [8];
  logic [3:0] unit_busy;
  vec_t tbl[17];
  vec_t sb[$];
  int n_vec = 0, n_bad = 0;
  resource_lock_arbiter dut (
    .clk(clk), .rst_n(rst_n), .rollback(rollback), .req_valid(req_valid), .req_id(req_id),
    .grant(grant), .grant_unit(grant_unit), .unit_busy(unit_busy), .timeout_pulse(timeout_pulse)
  );
  always #5 clk = ~clk;
  function automatic vec_t mk(logic r, logic b, logic [7:0] rv, logic [7:0] bump, logic [7:0] eg, logic [3:0] eb, logic [31:0] egu);
    vec_t v;
    v.rst_n = r; v.rb = b; v.rv = rv; v.bump = bump; v.eg = eg; v.eb = eb; v.egu = egu;
    return v;
  endfunction
  task automatic drive(vec_t v);
    rst_n = v.rst_n;
    rollback = v.rb;
    req_valid = v.rv;
    for (int i = 0; i < 8; i++) req_id[i] = {8'(i), 8'h10} + 16'(v.bump[i]);
    sb.push_back(v);
  endtask
  task automatic cmp(string name, int idx, logic [31:0] act, logic [31:0] exp);
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s vec %0d: got %h want %h", name, idx, act, exp);
    end
  endtask
  task automatic step(int idx);
    vec_t e;
    @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (sb.size() == 0) begin
      n_bad++;
      $display("FAIL scoreboard vec %0d: got empty queue want entry", idx);
    end else begin
      e = sb.pop_front();
      cmp("grant", idx, 32'(grant), 32'(e.eg));
      cmp("unit_busy", idx, 32'(unit_busy), 32'(e.eb));
      cmp("timeout_pulse", idx, 32'(timeout_pulse), 32'd0);
      for (int i = 0; i < 8; i++) cmp($sformatf("grant_unit[%0d]", i), idx, 32'(grant_unit[i]), 32'(e.egu[4*i +: 2]));
    end
  endtask
  initial begin
    tbl[0]  = mk(0, 0, 8'h00, 8'h00, 8'h00, 4'h0, 32'h0000_0000);
    tbl[1]  = mk(1, 0, 8'h3F, 8'h00, 8'h0F, 4'hF, 32'h0000_3210);
    tbl[2]  = mk(1, 0, 8'h3F, 8'h00, 8'h0F, 4'hF, 32'h0000_3210);
    tbl[3]  = mk(1, 0, 8'h3B, 8'h00, 8'h0B, 4'hB, 32'h0000_3010);
    tbl[4]  = mk(1, 0, 8'h3B, 8'h00, 8'h1B, 4'hF, 32'h0002_3010);
    tbl[5]  = mk(1, 1, 8'h3B, 8'h00, 8'h00, 4'h0, 32'h0000_0000);
    tbl[6]  = mk(1, 0, 8'h3B, 8'h00, 8'h2B, 4'hF, 32'h0000_3021);
    tbl[7]  = mk(1, 0, 8'h2B, 8'h01, 8'h2A, 4'hD, 32'h0000_3020);
    tbl[8]  = mk(1, 0, 8'h2B, 8'h01, 8'h2B, 4'hF, 32'h0000_3021);
    tbl[9]  = mk(0, 0, 8'h2B, 8'h00, 8'h00, 4'h0, 32'h0000_0000);
    tbl[10] = mk(1, 0, 8'hC1, 8'h00, 8'hC1, 4'h7, 32'h2100_0000);
    tbl[11] = mk(1, 0, 8'hC9, 8'h00, 8'hC9, 4'hF, 32'h2100_3000);
    tbl[12] = mk(1, 0, 8'h00, 8'h00, 8'h00, 4'h0, 32'h0000_0000);
    tbl[13] = mk(1, 0, 8'h30, 8'h00, 8'h30, 4'h3, 32'h0010_0000);
    tbl[14] = mk(1, 0, 8'hFF, 8'h00, 8'hF0, 4'hF, 32'h3210_0000);
    tbl[15] = mk(1, 0, 8'hFF, 8'h00, 8'hF0, 4'hF, 32'h3210_0000);
    tbl[16] = mk(1, 0, 8'h00, 8'h00, 8'h00, 4'h0, 32'h0000_0000);
    for (int i = 0; i < 17; i++) begin
      drive(tbl[i]);
      step(i);
    end
`ifndef RESOURCE_LOCK_WATCHDOG_EN
    for (int i = 0; i < 300; i++) begin
      drive(mk(1, 0, 8'h04, 8'h00, 8'h04, 4'h1, 32'h0000_0000));
      step(100 + i);
    end
    drive(mk(1, 0, 8'h00, 8'h00, 8'h00, 4'h0, 32'h0000_0000));
    step(400);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
